fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage sitting directly downstream of Instruction_Memory.
- Owns the fetch PC and drives the instruction memory address. Captures the combinational read data into a small prefetch FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Supports a redirect that flushes the queue (branch/jump) and a fetch stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, 2 to 16.
- RESET_PC, 32'h00000000, fetch PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc.
- imem_rdata  input  32  instruction word returned combinationally for imem_addr in the same cycle.
- imem_en  output  1  high in cycles where imem_rdata is captured (push).
- fetch_stall  input  1  suppresses new fetches; the queue is held, not flushed.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- count  output  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = RESET_PC.
  - Write pointer, read pointer and count = 0.
  - out_valid = 0, out_pc = 0, out_instr = 0, imem_en = 0.
  - Storage contents do not matter.
- Fetch state is implicit: FILL (count < DEPTH), FULL (count == DEPTH), STALL (fetch_stall=1).
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & ~fetch_stall & (count < DEPTH | pop).
  - Push while full is permitted only when a pop occurs in the same cycle.
- imem_en = push (combinational).
- On a push at the clock edge:
  - The entry at the write pointer stores {fetch_pc, imem_rdata}.
  - The write pointer increments modulo DEPTH.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (32'hFFFFFFFC to 0).
- On a pop, the read pointer increments modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - both: unchanged.
  - neither: unchanged.
- Output timing:
  - out_valid = (count != 0) & ~redirect_valid.
  - out_pc and out_instr come from the head entry when count != 0, else 0.
  - Latency: an instruction fetched at edge N is visible on the outputs from cycle N+1.
- Redirect (highest priority):
  - At the edge, pointers and count go to 0 and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop occur in that cycle, and out_valid is forced low that cycle.
  - The first instruction at the new PC is pushed in the following cycle, unless stalled.
- redirect_valid together with fetch_stall: the redirect still flushes and loads the PC; fetch resumes when the stall drops.
- fetch_stall=1: fetch_pc frozen and no push. Pops continue normally.
- Ordering: strict FIFO. Entries leave in PC order between redirects.
- Empty with out_ready=1: no pop, count stays 0.
- Reset mid-operation discards all entries immediately, regardless of handshake state.

Optional Feature:
- Macro: FETCH_FAULT_INJECT_EN.
- Defined:
  - Adds inputs fault_en (1) and fault_mask (32).
  - When fault_en=1 during a push, the stored instruction is imem_rdata ^ fault_mask.
  - The PC is never corrupted.
  - Adds output fault_hit (1), registered: high for one cycle after any push with fault_en=1 and fault_mask != 0; reset 0.
- Undefined: these ports do not exist, and the stored instruction is always imem_rdata.

Test Plan:
1. Reset release, imem model holds OR/AND/ADD words at addresses 0/4/8, out_ready=1:
   - Cycle 1 after release: out_valid=1, out_pc=0, out_instr=32'h0062E233.
   - Next: out_pc=4, out_instr=32'h00B67433.
   - Next: out_pc=8, out_instr=32'h00B60933.
2. out_ready=0 from reset, DEPTH=4:
   - count rises 1,2,3,4 then holds; imem_en=0 and imem_addr=16 while full.
   - Raise out_ready: pop and push coincide, count stays 4, out_pc steps 0,4,8.
3. Queue holding PCs 0..12, redirect_valid=1 with redirect_pc=32'h00000102:
   - That cycle: out_valid=0.
   - Next cycle: count=0 and imem_addr=32'h100.
   - Following cycle: out_pc=32'h100.
4. fetch_stall=1 for 3 cycles with out_ready=1 and count=2:
   - Queue drains to 0 and imem_addr stays constant.
   - Stall release resumes at the same PC with no gap or duplicate.
5. RESET_PC=32'hFFFFFFF8: pushed PCs are FFFFFFF8, FFFFFFFC, 00000000.
6. FETCH_FAULT_INJECT_EN defined, fault_en=1, fault_mask=32'h00000001 on the fetch of address 0:
   - out_instr=32'h0062E232 and fault_hit pulses for one cycle.
   - Subsequent fetches with fault_en=0 are unmodified.
   - Reset asserted mid-test: count=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, captures combinational imem data into a DEPTH-entry FIFO and hands {pc, instr} to decode.
// Optional build macro FETCH_FAULT_INJECT_EN adds fault_en/fault_mask inputs and a registered fault_hit output.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       imem_en,
  input  logic                       fetch_stall,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_FAULT_INJECT_EN
  ,
  input  logic                       fault_en,
  input  logic [31:0]                fault_mask,
  output logic                       fault_hit
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc_mem  [DEPTH];
  logic [31:0]   r_ins_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_fetch_pc;

  logic          w_nonempty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_wr_instr;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = w_nonempty & out_ready & ~redirect_valid;
  // Gated by rst so imem_en reads 0 while reset is held.
  assign w_push     = rst & ~redirect_valid & ~fetch_stall & (~w_full | w_pop);

`ifdef FETCH_FAULT_INJECT_EN
  logic r_fault_hit;

  assign w_wr_instr = fault_en ? (imem_rdata ^ fault_mask) : imem_rdata;
  assign fault_hit  = r_fault_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault_hit <= 1'b0;
    end else begin
      r_fault_hit <= w_push & fault_en & (fault_mask != 32'h0);
    end
  end
`else
  assign w_wr_instr = imem_rdata;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]  <= r_fetch_pc;
      r_ins_mem[r_wptr] <= w_wr_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc & ~32'h3;
    end else begin
      if (w_push) begin
        r_wptr     <= r_wptr + AW'(1);
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_addr = r_fetch_pc;
  assign imem_en   = w_push;
  assign out_valid = w_nonempty & ~redirect_valid;
  assign out_pc    = w_nonempty ? r_pc_mem[r_rptr]  : 32'h0;
  assign out_instr = w_nonempty ? r_ins_mem[r_rptr] : 32'h0;
  assign count     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_en;
  logic        fetch_stall, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  count;
  logic        fault_en;
  logic [31:0] fault_mask;
  logic        fault_hit;

  logic [31:0] hi_addr, hi_rdata, hi_pc, hi_instr;
  logic        hi_en, hi_valid;
  logic [2:0]  hi_count;
  logic        hi_fault_hit;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0062E233;
      32'h4:   return 32'h00B67433;
      32'h8:   return 32'h00B60933;
      default: return (a * 32'h9E3779B1) ^ 32'h00000013;
    endcase
  endfunction

  assign imem_rdata = imem_fn(imem_addr);
  assign hi_rdata   = imem_fn(hi_addr);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_en(imem_en),
    .fetch_stall(fetch_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
`ifdef FETCH_FAULT_INJECT_EN
    , .fault_en(fault_en), .fault_mask(fault_mask), .fault_hit(fault_hit)
`endif
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst(rst),
    .imem_addr(hi_addr), .imem_rdata(hi_rdata), .imem_en(hi_en),
    .fetch_stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(hi_valid), .out_ready(1'b1), .out_pc(hi_pc), .out_instr(hi_instr),
    .count(hi_count)
`ifdef FETCH_FAULT_INJECT_EN
    , .fault_en(1'b0), .fault_mask(32'h0), .fault_hit(hi_fault_hit)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_push, m_pop, m_redir, m_fhit, m_fhit_next;
  logic [31:0] m_rpc;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply inputs for this cycle, then compare outputs against the model's view.
  task automatic drive(input logic st, input logic rv, input logic [31:0] rp, input logic rdy);
    logic        ev;
    logic [31:0] epc, ein;
    fetch_stall    = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
    #1;
    ev          = (mq.size() != 0) && !rv;
    epc         = (mq.size() != 0) ? mq[0].pc  : 32'h0;
    ein         = (mq.size() != 0) ? mq[0].ins : 32'h0;
    m_pop       = ev && rdy;
    m_push      = !rv && !st && ((mq.size() < 4) || m_pop);
    m_redir     = rv;
    m_rpc       = rp;
    m_fhit_next = m_push && fault_en && (fault_mask != 32'h0);
    chk("out_valid", {31'h0, out_valid}, {31'h0, ev});
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, ein);
    chk("imem_en", {31'h0, imem_en}, {31'h0, m_push});
    chk("imem_addr", imem_addr, m_pc);
    chk("count", {29'h0, count}, mq.size());
`ifdef FETCH_FAULT_INJECT_EN
    chk("fault_hit", {31'h0, fault_hit}, {31'h0, m_fhit});
`endif
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (m_redir) begin
      mq.delete();
      m_pc = {m_rpc[31:2], 2'b00};
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.pc  = m_pc;
        e.ins = fault_en ? (imem_fn(m_pc) ^ fault_mask) : imem_fn(m_pc);
        mq.push_back(e);
        m_pc  = m_pc + 32'd4;
      end
    end
    m_fhit = m_fhit_next;
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle and checks that everything clears without waiting for an edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_en", {31'h0, imem_en}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_hi_addr", hi_addr, 32'hFFFF_FFF8);
`ifdef FETCH_FAULT_INJECT_EN
    chk("rst_fault_hit", {31'h0, fault_hit}, 32'h0);
`endif
    mq.delete();
    m_pc   = 32'h0;
    m_fhit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    fetch_stall    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    fault_en       = 1'b0;
    fault_mask     = 32'h0;
    @(negedge clk);

    // Reset release streams 0/4/8 in order; the high-PC instance wraps through zero.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 1) begin
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_ins0", out_instr, 32'h0062E233);
        chk("t5_pc0", hi_pc, 32'hFFFF_FFF8);
      end
      if (i == 2) begin
        chk("t1_pc4", out_pc, 32'h4);
        chk("t1_ins4", out_instr, 32'h00B67433);
        chk("t5_pc1", hi_pc, 32'hFFFF_FFFC);
      end
      if (i == 3) begin
        chk("t1_pc8", out_pc, 32'h8);
        chk("t1_ins8", out_instr, 32'h00B60933);
        chk("t5_pc2", hi_pc, 32'h0);
      end
      tick();
    end

    // Fill to full with no consumer, then simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_count", {29'h0, count}, (i < 4) ? i : 4);
      if (i >= 4) begin
        chk("t2_en_full", {31'h0, imem_en}, 32'h0);
        chk("t2_addr_full", imem_addr, 32'h10);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk("t2_count_full", {29'h0, count}, 32'h4);
      chk("t2_pc", out_pc, 32'(i * 4));
      chk("t2_en_pop", {31'h0, imem_en}, 32'h1);
      tick();
    end

    // Redirect flushes a full queue and aligns the new PC.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    chk("t3_valid", {31'h0, out_valid}, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_count", {29'h0, count}, 32'h0);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_pc", out_pc, 32'h100);
    tick();

    // Stall drains the queue while the fetch PC holds.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t4_addr", imem_addr, 32'h8);
      chk("t4_en", {31'h0, imem_en}, 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_count", {29'h0, count}, 32'h0);
    chk("t4_addr_resume", imem_addr, 32'h8);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_pc_resume", out_pc, 32'h8);
    tick();

`ifdef FETCH_FAULT_INJECT_EN
    do_reset();
    fault_en   = 1'b1;
    fault_mask = 32'h1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    fault_en   = 1'b0;
    fault_mask = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_ins", out_instr, 32'h0062E232);
    chk("t6_hit", {31'h0, fault_hit}, 32'h1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_hit_low", {31'h0, fault_hit}, 32'h0);
    chk("t6_ins_clean", out_instr, 32'h00B67433);
    tick();
`endif

    // Reset while the queue is occupied.
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    do_reset();

    for (int i = 0; i < 3000; i++) begin
`ifdef FETCH_FAULT_INJECT_EN
      fault_en   = ($urandom_range(0, 7) == 0);
      fault_mask = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0;
`endif
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom,
            $urandom_range(0, 2) != 0);
      tick();
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
